// File: rtl/can_arb_ctrl.sv
// can_arb_ctrl: CAN-style wired-AND identifier arbitration (SOF, MSB-first ID bits, grant, IFS).
// Define CAN_ARB_STARVE_EN to build per-node saturating loss counters and starvation flags.
module can_arb_ctrl #(
  parameter int N_NODES    = 4,
  parameter int ID_W       = 11,
  parameter int IFS_LEN    = 3,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_NODES-1:0]         req,
  input  logic [N_NODES*ID_W-1:0]    id_in,
  output logic                       bus_bit,
  output logic [N_NODES-1:0]         node_tx,
  output logic                       busy,
  output logic                       grant_valid,
  output logic [$clog2(N_NODES)-1:0] grant_idx,
  output logic [ID_W-1:0]            grant_id,
  output logic                       tie,
  output logic [N_NODES-1:0]         lost,
  output logic [N_NODES-1:0]         starve
);
  localparam int IDX_W = $clog2(N_NODES);
  localparam int POP_W = $clog2(N_NODES + 1);
  localparam int CNT_W = (ID_W > 1) ? $clog2(ID_W) : 1;
  localparam int IFS_W = $clog2(IFS_LEN + 1);

  typedef enum logic [2:0] {IDLE, SOF, ARB, GRANT, IFS} state_t;

  state_t             state_q, state_d;
  logic [N_NODES-1:0] active_q, active_d;
  logic [N_NODES-1:0] snap_q, snap_d;
  logic [ID_W-1:0]    ids_q [N_NODES];
  logic [ID_W-1:0]    ids_d [N_NODES];
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IFS_W-1:0]   ifs_cnt_q, ifs_cnt_d;

  logic               bus_bit_q, bus_bit_d;
  logic [N_NODES-1:0] node_tx_q, node_tx_d;
  logic               busy_q, busy_d;
  logic               grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               tie_q, tie_d;
  logic [N_NODES-1:0] lost_q, lost_d;

  logic [IDX_W-1:0]   win_idx;
  logic [POP_W-1:0]   pop_cnt;

  // Survivor selection: lowest surviving index wins; more than one survivor is a tie.
  always_comb begin
    win_idx = '0;
    pop_cnt = '0;
    for (int i = N_NODES - 1; i >= 0; i--) begin
      if (active_q[i]) win_idx = IDX_W'(i);
    end
    for (int i = 0; i < N_NODES; i++) begin
      pop_cnt = pop_cnt + POP_W'(active_q[i]);
    end
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    snap_d        = snap_q;
    bit_cnt_d     = bit_cnt_q;
    ifs_cnt_d     = ifs_cnt_q;
    for (int i = 0; i < N_NODES; i++) ids_d[i] = ids_q[i];
    bus_bit_d     = 1'b1;
    node_tx_d     = '1;
    busy_d        = (state_q != IDLE);
    grant_valid_d = 1'b0;
    grant_idx_d   = grant_idx_q;
    grant_id_d    = grant_id_q;
    tie_d         = 1'b0;
    lost_d        = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          active_d = req;
          snap_d   = req;
          for (int i = 0; i < N_NODES; i++) ids_d[i] = id_in[i*ID_W +: ID_W];
          state_d  = SOF;
        end
      end
      SOF: begin
        bus_bit_d = 1'b0;
        node_tx_d = ~active_q;
        bit_cnt_d = CNT_W'(ID_W - 1);
        state_d   = ARB;
      end
      ARB: begin
        for (int i = 0; i < N_NODES; i++) begin
          node_tx_d[i] = active_q[i] ? ids_q[i][bit_cnt_q] : 1'b1;
        end
        bus_bit_d = &node_tx_d;
        // A node sending recessive while the bus reads dominant has lost.
        active_d  = active_q & ~(node_tx_d & {N_NODES{~bus_bit_d}});
        if (bit_cnt_q == '0) begin
          state_d = GRANT;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      GRANT: begin
        grant_valid_d = 1'b1;
        grant_idx_d   = win_idx;
        grant_id_d    = ids_q[win_idx];
        tie_d         = (pop_cnt > POP_W'(1));
        lost_d        = snap_q & ~(N_NODES'(1) << win_idx);
        ifs_cnt_d     = '0;
        state_d       = IFS;
      end
      IFS: begin
        if (ifs_cnt_q == IFS_W'(IFS_LEN - 1)) begin
          state_d = IDLE;
        end else begin
          ifs_cnt_d = ifs_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      active_q      <= '0;
      snap_q        <= '0;
      for (int i = 0; i < N_NODES; i++) ids_q[i] <= '0;
      bit_cnt_q     <= '0;
      ifs_cnt_q     <= '0;
      bus_bit_q     <= 1'b1;
      node_tx_q     <= '1;
      busy_q        <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      grant_id_q    <= '0;
      tie_q         <= 1'b0;
      lost_q        <= '0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      snap_q        <= snap_d;
      for (int i = 0; i < N_NODES; i++) ids_q[i] <= ids_d[i];
      bit_cnt_q     <= bit_cnt_d;
      ifs_cnt_q     <= ifs_cnt_d;
      bus_bit_q     <= bus_bit_d;
      node_tx_q     <= node_tx_d;
      busy_q        <= busy_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      grant_id_q    <= grant_id_d;
      tie_q         <= tie_d;
      lost_q        <= lost_d;
    end
  end

  assign bus_bit     = bus_bit_q;
  assign node_tx     = node_tx_q;
  assign busy        = busy_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign grant_id    = grant_id_q;
  assign tie         = tie_q;
  assign lost        = lost_q;

`ifdef CAN_ARB_STARVE_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0]    loss_cnt_q [N_NODES];
  logic [SC_W-1:0]    loss_cnt_d [N_NODES];
  logic [N_NODES-1:0] starve_q, starve_d;

  // Counters follow the registered grant/lost pulses; dropping req forgives past losses.
  always_comb begin
    for (int i = 0; i < N_NODES; i++) begin
      loss_cnt_d[i] = loss_cnt_q[i];
      if (!req[i] || (grant_valid_q && grant_idx_q == IDX_W'(i))) begin
        loss_cnt_d[i] = '0;
      end else if (lost_q[i] && loss_cnt_q[i] != SC_W'(STARVE_MAX)) begin
        loss_cnt_d[i] = loss_cnt_q[i] + 1'b1;
      end
      starve_d[i] = (loss_cnt_d[i] >= SC_W'(STARVE_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_NODES; i++) loss_cnt_q[i] <= '0;
      starve_q <= '0;
    end else begin
      for (int i = 0; i < N_NODES; i++) loss_cnt_q[i] <= loss_cnt_d[i];
      starve_q <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  assign starve = '0;
`endif

endmodule

// File: tb/tb_can_arb_ctrl.sv
// tb_can_arb_ctrl: directed rounds against a bench-side arbitration timeline model.
`timescale 1ns/1ps
module tb_can_arb_ctrl;
  localparam int N         = 4;
  localparam int W         = 11;
  localparam int IFS       = 3;
  localparam int SMAX      = 8;
  localparam int ROUND_END = W + 1 + IFS;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   id_in = '0;
  logic             bus_bit;
  logic [N-1:0]     node_tx;
  logic             busy;
  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic [W-1:0]     grant_id;
  logic             tie;
  logic [N-1:0]     lost;
  logic [N-1:0]     starve;

  can_arb_ctrl #(.N_NODES(N), .ID_W(W), .IFS_LEN(IFS), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .req(req), .id_in(id_in),
    .bus_bit(bus_bit), .node_tx(node_tx), .busy(busy),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .grant_id(grant_id),
    .tie(tie), .lost(lost), .starve(starve)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;
  bit cmp_en      = 1'b0;

  // Model state: phase counts edges since the snapshot edge, -1 while idle.
  int           phase = -1;
  logic [N-1:0] m_snap = '0;
  logic [W-1:0] m_ids [N];
  int           starve_cnt [N];
  logic         exp_bus = 1'b1;
  logic [N-1:0] exp_tx = '1;
  logic         exp_busy = 1'b0;
  logic         exp_gv = 1'b0;
  int           exp_idx = 0;
  logic [W-1:0] exp_gid = '0;
  logic         exp_tie = 1'b0;
  logic [N-1:0] exp_lost = '0;
  logic [N-1:0] exp_starve = '0;
  logic [W-1:0] mn;
  int           b, win, nwin;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    check_count++;
    if (act === expv) pass_count++;
    else $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] ids);
    req   = r;
    id_in = ids;
  endtask

  function automatic logic [W-1:0] min_snap_id();
    logic [W-1:0] m;
    m = '1;
    for (int i = 0; i < N; i++) if (m_snap[i] && m_ids[i] < m) m = m_ids[i];
    return m;
  endfunction

  // Outputs after each edge describe the round position held before that edge.
  always @(posedge clk) begin
    if (!rst) begin
      phase = -1;
      exp_bus = 1'b1; exp_tx = '1; exp_busy = 1'b0; exp_gv = 1'b0;
      exp_idx = 0; exp_gid = '0; exp_tie = 1'b0; exp_lost = '0; exp_starve = '0;
      for (int i = 0; i < N; i++) starve_cnt[i] = 0;
    end else begin
`ifdef CAN_ARB_STARVE_EN
      for (int i = 0; i < N; i++) begin
        if (!req[i] || (exp_gv && exp_idx == i)) starve_cnt[i] = 0;
        else if (exp_lost[i] && starve_cnt[i] < SMAX) starve_cnt[i]++;
        exp_starve[i] = (starve_cnt[i] >= SMAX);
      end
`endif
      mn = min_snap_id();
      exp_bus = 1'b1; exp_tx = '1; exp_busy = (phase >= 0);
      exp_gv = 1'b0; exp_tie = 1'b0; exp_lost = '0;
      if (phase == 0) begin
        exp_bus = 1'b0;
        exp_tx  = ~m_snap;
      end else if (phase >= 1 && phase <= W) begin
        b = W - phase;
        exp_bus = mn[b];
        for (int i = 0; i < N; i++)
          if (m_snap[i] && ((m_ids[i] >> (b + 1)) == (mn >> (b + 1)))) exp_tx[i] = m_ids[i][b];
      end else if (phase == W + 1) begin
        win = -1; nwin = 0;
        for (int i = 0; i < N; i++)
          if (m_snap[i] && m_ids[i] == mn) begin
            nwin++;
            if (win < 0) win = i;
          end
        exp_gv = 1'b1; exp_idx = win; exp_gid = m_ids[win];
        exp_tie = (nwin > 1);
        exp_lost = m_snap & ~(N'(1) << win);
      end
      if (phase < 0) begin
        if (|req) begin
          m_snap = req;
          for (int i = 0; i < N; i++) m_ids[i] = id_in[i*W +: W];
          phase = 0;
        end
      end else if (phase == ROUND_END) phase = -1;
      else phase++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("bus_bit", bus_bit, exp_bus);
      checkOutput("node_tx", node_tx, exp_tx);
      checkOutput("busy", busy, exp_busy);
      checkOutput("grant_valid", grant_valid, exp_gv);
      checkOutput("tie", tie, exp_tie);
      checkOutput("lost", lost, exp_lost);
      checkOutput("starve", starve, exp_starve);
      if (exp_gv) begin
        checkOutput("grant_idx", grant_idx, exp_idx);
        checkOutput("grant_id", grant_id, exp_gid);
      end
    end
  end

  task automatic runRound(input logic [N-1:0] r, input logic [N*W-1:0] ids,
                          input logic [W-1:0] e_bits, input int e_idx, input logic [W-1:0] e_id,
                          input logic e_tie, input logic [N-1:0] e_lost, input logic [N-1:0] r_after);
    logic [W-1:0] seen;
    seen = '0;
    applyStimulus(r, ids);
    for (int n = 1; n <= W + 3; n++) begin
      @(negedge clk);
      if (n == 2) checkOutput("lit_sof_bus", bus_bit, 1'b0);
      if (n >= 3 && n <= W + 2) seen[W+2-n] = bus_bit;
    end
    checkOutput("lit_arb_bits", seen, e_bits);
    checkOutput("lit_grant_latency", grant_valid, 1'b1);
    checkOutput("lit_grant_idx", grant_idx, e_idx);
    checkOutput("lit_grant_id", grant_id, e_id);
    checkOutput("lit_tie", tie, e_tie);
    checkOutput("lit_lost", lost, e_lost);
    applyStimulus(r_after, ids);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    applyStimulus('0, '0);
    repeat (3) @(negedge clk);
    checkOutput("rst_bus", bus_bit, 1'b1);
    checkOutput("rst_node_tx", node_tx, 4'hF);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_grant_valid", grant_valid, 1'b0);
    checkOutput("rst_grant_idx", grant_idx, 2'd0);
    checkOutput("rst_grant_id", grant_id, 11'h000);
    checkOutput("rst_tie", tie, 1'b0);
    checkOutput("rst_lost", lost, 4'h0);
    checkOutput("rst_starve", starve, 4'h0);
    cmp_en = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_bus", bus_bit, 1'b1);

    $display("[TB] single requester");
    runRound(4'b0100, {11'h000, 11'h123, 11'h000, 11'h000}, 11'h123, 2, 11'h123, 1'b0, 4'b0000, 4'b0000);
    repeat (IFS + 3) @(negedge clk);

    $display("[TB] two-node LSB contest and automatic retry");
    runRound(4'b0011, {11'h000, 11'h000, 11'h064, 11'h065}, 11'h064, 1, 11'h064, 1'b0, 4'b0001, 4'b0001);
    repeat (IFS) @(negedge clk);
    runRound(4'b0001, {11'h000, 11'h000, 11'h064, 11'h065}, 11'h065, 0, 11'h065, 1'b0, 4'b0000, 4'b0000);
    repeat (IFS + 3) @(negedge clk);

    $display("[TB] identical identifiers");
    runRound(4'b1010, {11'h7F0, 11'h001, 11'h7F0, 11'h000}, 11'h7F0, 1, 11'h7F0, 1'b1, 4'b1000, 4'b0000);
    repeat (IFS + 3) @(negedge clk);

    $display("[TB] reset mid-round");
    applyStimulus(4'b0001, {11'h000, 11'h000, 11'h000, 11'h2AA});
    repeat (8) @(negedge clk);
    checkOutput("lit_bit5_bus", bus_bit, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_bus", bus_bit, 1'b1);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_grant_valid", grant_valid, 1'b0);
    checkOutput("midrst_node_tx", node_tx, 4'hF);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_idle_bus", bus_bit, 1'b1);
    @(negedge clk);
    checkOutput("post_rst_sof_bus", bus_bit, 1'b0);
    repeat (W + 1) @(negedge clk);
    checkOutput("post_rst_grant", grant_valid, 1'b1);
    checkOutput("post_rst_grant_id", grant_id, 11'h2AA);
    applyStimulus(4'b0000, id_in);
    repeat (IFS + 3) @(negedge clk);

`ifdef CAN_ARB_STARVE_EN
    $display("[TB] starvation");
    applyStimulus(4'b1001, {11'h7FF, 11'h000, 11'h000, 11'h000});
    for (int g = 1; g <= SMAX; g++) begin
      int waited;
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!grant_valid && waited < 40);
      if (!grant_valid) begin
        checkOutput("starve_grant_timeout", 1'b0, 1'b1);
        break;
      end
    end
    checkOutput("lit_starve_lost3", lost[3], 1'b1);
    checkOutput("lit_starve_before", starve[3], 1'b0);
    @(negedge clk);
    checkOutput("lit_starve_rise", starve[3], 1'b1);
    applyStimulus(4'b0001, id_in);
    @(negedge clk);
    checkOutput("lit_starve_clear", starve[3], 1'b0);
    applyStimulus(4'b0000, id_in);
    repeat (W + IFS + 6) @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
